// File: rtl/core_pkg.sv
// Shared constants for the core instruction sequencer: tile geometry, inst bit map and FSM states.
package core_pkg;

   localparam int ROW     = 8;
   localparam int COL     = 8;
   localparam int ADDR_BW = 11;
   localparam int CNT_W   = ADDR_BW + 1;
   localparam int INST_W  = 37;

   localparam int B_XMEM_BYP = 35;
   localparam int B_ACC      = 33;
   localparam int B_CEN_PMEM = 32;
   localparam int B_WEN_PMEM = 31;
   localparam int A_PMEM_LSB = 20;
   localparam int B_CEN_XMEM = 19;
   localparam int B_WEN_XMEM = 18;
   localparam int A_XMEM_LSB = 7;
   localparam int B_OFIFO_RD = 6;
   localparam int B_IFIFO_WR = 5;
   localparam int B_IFIFO_RD = 4;
   localparam int B_L0_RD    = 3;
   localparam int B_L0_WR    = 2;
   localparam int B_EXEC     = 1;
   localparam int B_LOAD     = 0;

   // Both SRAMs disabled and in read mode, every strobe low.
   localparam logic [INST_W-1:0] INST_IDLE = 37'h1_800C_0000;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WXFER = 3'd1,
      S_WLOAD = 3'd2,
      S_GAP   = 3'd3,
      S_AXFER = 3'd4,
      S_EXEC  = 3'd5,
      S_DRAIN = 3'd6
   } seq_state_e;

endpackage

// File: rtl/core_seq.sv
// One-tile-pass instruction sequencer for core: weights in, weights to PEs, activations in,
// execute, then drain OFIFO to pmem. A single phase counter drives every state.
module core_seq
   import core_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [ADDR_BW-1:0]  num_act,
   input  logic [ADDR_BW-1:0]  w_base,
   input  logic [ADDR_BW-1:0]  a_base,
   input  logic [ADDR_BW-1:0]  p_base,
   input  logic                ofifo_valid,
   output logic [INST_W-1:0]   inst,
   output logic                busy,
   output logic                done
);

   seq_state_e         r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [ADDR_BW-1:0] r_num, r_xbase, r_abase, r_pbase;
   logic               r_rd_dly, r_zero_done;

   logic               w_capture, w_ld_a, w_zero_start;
   logic               w_xrd, w_pwr, w_l0_rd, w_load, w_exec, w_last_wr;
   logic [CNT_W-1:0]   w_num_ext;
   logic [ADDR_BW-1:0] w_xaddr, w_paddr;

   assign w_num_ext = {1'b0, r_num};
   assign w_xaddr   = r_xbase + r_cnt[ADDR_BW-1:0];
   assign w_paddr   = r_pbase + r_cnt[ADDR_BW-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_num       <= '0;
         r_xbase     <= '0;
         r_abase     <= '0;
         r_pbase     <= '0;
         r_rd_dly    <= 1'b0;
         r_zero_done <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_rd_dly    <= w_xrd;
         r_zero_done <= w_zero_start;
         if (w_capture) begin
            r_num   <= num_act;
            r_xbase <= w_base;
            r_abase <= a_base;
            r_pbase <= p_base;
         end else if (w_ld_a) begin
            r_xbase <= r_abase;
         end
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_capture    = 1'b0;
      w_ld_a       = 1'b0;
      w_zero_start = 1'b0;
      w_xrd        = 1'b0;
      w_pwr        = 1'b0;
      w_l0_rd      = 1'b0;
      w_load       = 1'b0;
      w_exec       = 1'b0;
      w_last_wr    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (num_act != '0) begin
                  w_capture   = 1'b1;
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_WXFER;
               end else begin
                  w_zero_start = 1'b1;
               end
            end
         end
         S_WXFER: begin
            // Last cycle issues no read; it only lets the final l0_wr land.
            w_xrd = (r_cnt < CNT_W'(COL));
            if (r_cnt == CNT_W'(COL)) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_WLOAD;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_WLOAD: begin
            w_l0_rd = 1'b1;
            w_load  = 1'b1;
            if (r_cnt == CNT_W'(COL + ROW - 1)) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_GAP;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_GAP: begin
            w_ld_a      = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_AXFER;
         end
         S_AXFER: begin
            w_xrd = (r_cnt < w_num_ext);
            if (r_cnt == w_num_ext) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_EXEC;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_EXEC: begin
            w_l0_rd = 1'b1;
            w_exec  = 1'b1;
            if (r_cnt == w_num_ext - 1'b1) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_DRAIN;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_DRAIN: begin
            // The write index only advances on cycles the OFIFO actually has data.
            if (ofifo_valid) begin
               w_pwr = 1'b1;
               if (r_cnt == w_num_ext - 1'b1) begin
                  w_last_wr   = 1'b1;
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
         end
         default: begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_comb begin
      inst = INST_IDLE;
      if (w_xrd) begin
         inst[B_CEN_XMEM]                   = 1'b0;
         inst[A_XMEM_LSB +: ADDR_BW]        = w_xaddr;
      end
      if (w_pwr) begin
         inst[B_CEN_PMEM]                   = 1'b0;
         inst[B_WEN_PMEM]                   = 1'b0;
         inst[A_PMEM_LSB +: ADDR_BW]        = w_paddr;
      end
      inst[B_OFIFO_RD] = w_pwr;
      inst[B_L0_RD]    = w_l0_rd;
      inst[B_L0_WR]    = r_rd_dly;
      inst[B_EXEC]     = w_exec;
      inst[B_LOAD]     = w_load;
   end

   assign busy = (r_state != S_IDLE);
   assign done = r_zero_done | w_last_wr;

endmodule

// File: tb/tb_core_seq.sv
// Scoreboard bench for core_seq: the driver queues expected xmem/pmem addresses at each start,
// a negedge monitor pops and compares them and tallies strobes.
module tb_core_seq;
  import core_pkg::*;

  logic                clk = 1'b0;
  logic                reset, start, ofifo_valid;
  logic [ADDR_BW-1:0]  num_act, w_base, a_base, p_base;
  logic [INST_W-1:0]   inst;
  logic                busy, done;

  always #5 clk = ~clk;

  core_seq dut (
    .clk(clk), .reset(reset), .start(start), .num_act(num_act),
    .w_base(w_base), .a_base(a_base), .p_base(p_base),
    .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy), .done(done)
  );

  int tests = 0;
  int fails = 0;
  logic [ADDR_BW-1:0] exp_x_q[$];
  logic [ADDR_BW-1:0] exp_p_q[$];
  int load_cnt = 0, exec_cnt = 0, done_cnt = 0;
  int valid_mode = 0, vphase = 0;
  logic prev_xrd = 1'b0;
  logic m_xrd, m_pwr;
  logic [ADDR_BW-1:0] m_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ofifo_valid: mode 0 tied high, mode 1 repeats 1,0,0.
  always @(posedge clk) begin
    #1;
    if (valid_mode == 0) ofifo_valid = 1'b1;
    else begin
      ofifo_valid = (vphase % 3 == 0);
      vphase++;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (reset) begin
      prev_xrd = 1'b0;
    end else begin
      m_xrd = !inst[B_CEN_XMEM];
      m_pwr = !inst[B_CEN_PMEM];
      check("mem_excl", {63'b0, m_xrd & m_pwr}, 64'd0);
      check("load_exec_excl", {63'b0, inst[B_LOAD] & inst[B_EXEC]}, 64'd0);
      check("fixed_zero_bits", {58'b0, inst[36:33], inst[B_IFIFO_WR], inst[B_IFIFO_RD]}, 64'd0);
      check("l0_wr_lag", {63'b0, inst[B_L0_WR]}, {63'b0, prev_xrd});
      if (m_xrd) begin
        check("xmem_wen", {63'b0, inst[B_WEN_XMEM]}, 64'd1);
        if (exp_x_q.size() == 0) begin
          check("xmem_unexpected_read", 64'd1, 64'd0);
        end else begin
          m_exp = exp_x_q.pop_front();
          check("xmem_addr", {53'b0, inst[A_XMEM_LSB +: ADDR_BW]}, {53'b0, m_exp});
        end
      end
      if (m_pwr) begin
        check("pmem_wen", {63'b0, inst[B_WEN_PMEM]}, 64'd0);
        check("pmem_on_valid", {62'b0, inst[B_OFIFO_RD], ofifo_valid}, 64'd3);
        if (exp_p_q.size() == 0) begin
          check("pmem_unexpected_write", 64'd1, 64'd0);
        end else begin
          m_exp = exp_p_q.pop_front();
          check("pmem_addr", {53'b0, inst[A_PMEM_LSB +: ADDR_BW]}, {53'b0, m_exp});
        end
      end else begin
        check("ofifo_rd_idle", {63'b0, inst[B_OFIFO_RD]}, 64'd0);
      end
      if (inst[B_LOAD]) load_cnt++;
      if (inst[B_EXEC]) exec_cnt++;
      if (done) begin
        done_cnt++;
        check("done_after_last_write", 64'(exp_p_q.size()), 64'd0);
      end
      prev_xrd = m_xrd;
    end
  end

  task automatic clear_sb();
    exp_x_q.delete();
    exp_p_q.delete();
    load_cnt = 0;
    exec_cnt = 0;
    done_cnt = 0;
  endtask

  // Pulse start and queue the expected transfers: col weight reads, n activation reads, n writes.
  task automatic issue(input logic [ADDR_BW-1:0] w, input logic [ADDR_BW-1:0] a,
                       input logic [ADDR_BW-1:0] p, input logic [ADDR_BW-1:0] n,
                       input bit push);
    @(posedge clk); #1;
    w_base = w; a_base = a; p_base = p; num_act = n; start = 1'b1;
    if (push && n != 0) begin
      for (int k = 0; k < COL; k++) exp_x_q.push_back(w + ADDR_BW'(k));
      for (int k = 0; k < int'(n); k++) exp_x_q.push_back(a + ADDR_BW'(k));
      for (int k = 0; k < int'(n); k++) exp_p_q.push_back(p + ADDR_BW'(k));
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic end_pass(input string name, input int n);
    int budget;
    budget = 0;
    while (done_cnt == 0 && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    check({name, "_done_timeout"}, {63'b0, done_cnt == 0}, 64'd0);
    repeat (3) @(negedge clk);
    check({name, "_done_count"}, 64'(done_cnt), 64'd1);
    check({name, "_load_cycles"}, 64'(load_cnt), 64'(COL + ROW));
    check({name, "_exec_cycles"}, 64'(exec_cnt), 64'(n));
    check({name, "_xmem_left"}, 64'(exp_x_q.size()), 64'd0);
    check({name, "_pmem_left"}, 64'(exp_p_q.size()), 64'd0);
    check({name, "_idle_inst"}, {27'b0, inst}, {27'b0, 37'h1_800C_0000});
    check({name, "_idle_busy"}, {63'b0, busy}, 64'd0);
    clear_sb();
  endtask

  initial begin
    int budget;
    reset = 1'b1; start = 1'b0; num_act = '0; w_base = '0; a_base = '0; p_base = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_inst", {27'b0, inst}, {27'b0, 37'h1_800C_0000});
    check("reset_busy_done", {62'b0, busy, done}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic pass: xmem 0..7 then 16..19, pmem 0..3.
    issue(11'd0, 11'd16, 11'd0, 11'd4, 1'b1);
    end_pass("basic", 4);

    // Sparse ofifo_valid during drain.
    valid_mode = 1; vphase = 0;
    issue(11'd0, 11'd16, 11'd0, 11'd4, 1'b1);
    end_pass("sparse_valid", 4);
    valid_mode = 0;

    // Wrap: xmem 2046,2047,0,1 and pmem 2045,2046,2047,0.
    issue(11'd0, 11'd2046, 11'd2045, 11'd4, 1'b1);
    end_pass("wrap", 4);

    // Zero-length pass: done one cycle later, never busy, no SRAM enable.
    @(posedge clk); #1;
    num_act = '0; start = 1'b1;
    @(negedge clk);
    check("zero_before_done", {62'b0, busy, done}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("zero_done_pulse", {62'b0, busy, done}, 64'd1);
    @(negedge clk);
    check("zero_done_drop", {62'b0, busy, done}, 64'd0);
    check("zero_done_count", 64'(done_cnt), 64'd1);
    clear_sb();

    // Start re-pulsed while loading weights is ignored.
    issue(11'd0, 11'd16, 11'd0, 11'd4, 1'b1);
    budget = 0;
    while (load_cnt == 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check("repulse_reach_load", {63'b0, load_cnt == 0}, 64'd0);
    issue(11'd100, 11'd200, 11'd300, 11'd5, 1'b0);
    end_pass("repulse", 4);

    // Reset in the middle of execute, then a full pass.
    issue(11'd0, 11'd16, 11'd0, 11'd4, 1'b1);
    budget = 0;
    while (exec_cnt == 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check("midreset_reach_exec", {63'b0, exec_cnt == 0}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    clear_sb();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("midreset_inst", {27'b0, inst}, {27'b0, 37'h1_800C_0000});
    check("midreset_busy", {63'b0, busy}, 64'd0);
    repeat (3) @(negedge clk);
    check("midreset_quiet", {32'(load_cnt + exec_cnt), 32'(done_cnt)}, 64'd0);
    issue(11'd8, 11'd40, 11'd64, 11'd4, 1'b1);
    end_pass("after_reset", 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
